// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and the circular priority search
// for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDW   = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  // Rotating right by ptr puts requester ptr at bit 0, so the lowest set
  // bit of the rotated vector is the circular winner relative to ptr.
  function automatic logic [IDW-1:0] rrPick(input logic [N_REQ-1:0] req,
                                            input logic [IDW-1:0]   ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDW-1:0]     off;
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    return off + ptr;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle: the master drives requests and enable, the
// arbiter (slave) returns the registered grant outputs.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output en, req,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  en, req,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter8_grant_decoder.sv
// Index-to-one-hot decoder feeding the grant register; all-zero when
// the enable is low.
module rr_arbiter8_grant_decoder
  import rr_arbiter8_pkg::*;
(
  input  logic [IDW-1:0]   idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a per-tenure hold limit, one-cycle
// bus-turnaround gap and fully registered one-hot/encoded grant.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             gvalid_q, gvalid_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  // Release and timeout share one exit path; only the pulse differs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gid_d     = gid_q;
    gvalid_d  = gvalid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          gid_d    = rrPick(bus.req, ptr_q);
          gvalid_d = 1'b1;
          cnt_d    = CW'(1);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[gid_q] || (cnt_q == CW'(MAX_HOLD))) begin
          timeout_d = bus.req[gid_q];
          ptr_d     = gid_q + IDW'(1);
          gid_d     = '0;
          gvalid_d  = 1'b0;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        gid_d    = '0;
        gvalid_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  rr_arbiter8_grant_decoder u_grant_decoder (
    .idx_i    (gid_d),
    .en_i     (gvalid_d),
    .onehot_o (grant_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gid_q     <= '0;
      gvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gid_q     <= gid_d;
      gvalid_q  <= gvalid_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = gid_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing one resource among eight requesters. Picks one active requester, holds the grant while its request stays high (up to a hold limit), then rotates priority. Grant is one-hot with an encoded index, so it can drive a shared bus mux or a chip-select bank directly. Sits between the requesting engines and the decoded-select fabric of the shared resource.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure; legal range 2..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  enables new grants; an ongoing tenure is not affected.
- req  in  8  request vector; bit i = requester i; held high for the whole tenure.
- grant  out  8  one-hot grant, registered; all-zero when idle.
- grant_id  out  3  index of granted requester; 0 when grant_valid=0.
- grant_valid  out  1  high while any grant bit is set.
- timeout  out  1  one-cycle pulse when a tenure ends by hold limit.

## Operation
- Reset (rst_n=0 at a clock edge): state IDLE, grant=8'h00, grant_id=0, grant_valid=0, timeout=0, priority pointer ptr=0, hold counter=0. Reset mid-tenure drops the grant at that edge, no timeout pulse.
- States: IDLE, GRANT, GAP.
- IDLE: if en=1 and req!=0, select the first set bit searching circularly from ptr upward (ptr, ptr+1, ..., 7, 0, ..., ptr-1, mod 8); go to GRANT with that grant, counter=1. Otherwise stay.
- GRANT: if req[grant_id]=0, go to GAP (normal release). Else if counter==MAX_HOLD, go to GAP and pulse timeout. Else counter+1, stay. Other req bits are ignored in GRANT.
- GAP: grant=0 for exactly one cycle (bus turnaround); ptr=(grant_id+1) mod 8 is loaded on GRANT exit; then IDLE. Arbitration happens in IDLE, so a GAP-to-GRANT path needs one IDLE evaluation cycle.
- Rotation: ptr changes only on tenure end, both release and timeout. A timed-out requester is regranted only if no other bit is set at the next IDLE evaluation.
- grant_id and grant change together; grant == (1 << grant_id) when grant_valid=1, else 0.
- en=0 during GRANT: the tenure runs to normal end; no new grant follows until en=1.
- Counter width: $clog2(MAX_HOLD+1) bits; it never wraps, because it saturates at MAX_HOLD and the tenure ends there.

## Timing
- Request to grant: req set at edge N while in IDLE with en=1 -> grant visible after edge N+1 (1-cycle latency).
- Tenure length: at most MAX_HOLD cycles of grant high.
- Release: req[i] low sampled at edge M -> grant low after edge M+1 (GAP), IDLE after M+2, next grant after M+3 at the earliest.
- Timeout: grant high for cycles 1..MAX_HOLD; at the edge ending cycle MAX_HOLD, grant drops and timeout=1 for that one cycle (GAP).
- Simultaneous requests at IDLE: single winner per the circular search; there are no ties.
- All outputs are registered; no combinational path from req to grant.

## Structure
- Shared package entries: localparam N_REQ=8, IDW=3, and the state enum (IDLE, GRANT, GAP).
- Sub-module grant_decoder: 3-bit index plus enable to 8-bit one-hot, purely combinational. It drives the grant register input from the next grant_id and the next valid.
- Circular priority search: rotate req right by ptr, take the lowest set bit, add ptr mod 8. Implemented inline as a function.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF -> grant=0, grant_id=0, grant_valid=0, timeout=0. Release reset -> first grant is 8'h01 one cycle later.
- Single requester: req=8'h10 for 5 cycles, then 0 -> grant=8'h10 (id 4) for 5 cycles, one GAP cycle at 0, then IDLE; timeout stays 0.
- Round-robin fairness: req=8'hFF held with each winner dropping its bit after 3 cycles and re-raising it in GAP -> grant order 0,1,2,...,7,0, with a 2-cycle gap between tenures.
- Timeout with MAX_HOLD=4: req=8'h05 held constant -> id 0 granted 4 cycles, timeout pulse, GAP, then id 2 for 4 cycles, timeout, then id 0.
- Timeout, lone requester: req=8'h80 constant, MAX_HOLD=4 -> id 7 repeats with 4 cycles on and 2 off, and timeout pulses every 6 cycles.
- Enable gating and mid-tenure reset: en=0 with req=8'h02 -> no grant. Set en=1 -> grant 8'h02, then en=0 -> grant holds until req drops. Separately, assert rst_n=0 mid-tenure -> grant=0 next edge, no timeout pulse, ptr=0.
